// File: rtl/mips_defs.sv
// mips_defs: shared fetch constants, exception codes and fetch sequencer states
package mips_defs;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT = 32'h0000_6ffc;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  typedef enum logic [1:0] {RUN, PEND, TRAP} state_t;
endpackage

// File: rtl/if_addr_chk.sv
// if_addr_chk: word-aligned instruction-memory window check
module if_addr_chk #(
  parameter logic [31:0] LO = 32'h0000_3000,
  parameter logic [31:0] HI = 32'h0000_6ffc
) (
  input  logic [31:0] addr,
  output logic        legal
);
  assign legal = addr[1:0] == 2'b00 && addr >= LO && addr <= HI;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: next-PC sequencer with redirect capture under stall and AdEL fetch trap
module if_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = mips_defs::PC_RESET,
  parameter logic [31:0] PC_LIMIT = mips_defs::PC_LIMIT,
  parameter logic [31:0] HANDLER_PC = mips_defs::HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        flush,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_vaddr
);
  import mips_defs::*;
  state_t state, state_n;
  logic [31:0] pend, pend_n, cand;
  logic legal, fault;
  assign cand = eret_req ? epc : state == PEND ? pend : br_valid ? br_target : pc + 32'd4;
  if_addr_chk #(.LO(PC_RESET), .HI(PC_LIMIT)) u_chk (.addr(cand), .legal(legal));
  always_comb begin
    next_pc = pc;
    pc_en = 1'b0;
    flush = 1'b0;
    state_n = state;
    pend_n = pend;
    fault = 1'b0;
    if (exc_req) begin
      next_pc = HANDLER_PC;
      pc_en = 1'b1;
      flush = 1'b1;
      state_n = RUN;
      pend_n = '0;
    end else if (eret_req) begin
      if (legal) begin
        next_pc = cand;
        pc_en = 1'b1;
        flush = 1'b1;
        state_n = RUN;
      end else fault = 1'b1;
    end else if (state != TRAP && !stall) begin
      if (legal) begin
        next_pc = cand;
        pc_en = 1'b1;
        state_n = RUN;
      end else fault = 1'b1;
    end else if (state == RUN && br_valid) begin
      pend_n = br_target;
      state_n = PEND;
    end
    if (fault) state_n = TRAP;
    if (reset) begin
      next_pc = PC_RESET;
      pc_en = 1'b0;
      flush = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pend <= '0;
      exc_code <= EXC_NONE;
      bad_vaddr <= '0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      exc_code <= state_n == TRAP ? EXC_ADEL : EXC_NONE;
      if (fault) bad_vaddr <= cand;
    end
  end
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Next-PC sequencer for the instruction fetch stage of the pipelined MIPS core. Each cycle it picks the next fetch address from five sources: sequential, branch/jump redirect, exception entry, ERET return and stall hold. It drives the fetch PC register's `next_pc`/`en` inputs and validates every candidate address against the instruction-memory window. An illegal target is trapped with ExcCode 4 (AdEL) until CP0 takes the exception.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, reset fetch address / low bound of the IM window
- `PC_LIMIT`, 32'h0000_6ffc, highest legal fetch address
- `HANDLER_PC`, 32'h0000_4180, exception entry address

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `pc`  in  32  current fetch PC from the PC register
- `stall`  in  1  hazard hold from decode
- `br_valid`  in  1  redirect request from D stage (branch taken / jump)
- `br_target`  in  32  redirect target
- `exc_req`  in  1  CP0 is taking an exception/interrupt this cycle
- `eret_req`  in  1  ERET in D stage
- `epc`  in  32  return address from CP0
- `next_pc`  out  32  combinational, to PC register
- `pc_en`  out  1  combinational, PC register load enable
- `flush`  out  1  combinational, kill IF/ID contents
- `exc_code`  out  5  registered, 4 while trapped, else 0
- `bad_vaddr`  out  32  registered, offending fetch address

## Operation
- States: RUN, PEND (redirect captured under stall), TRAP (fetch address fault outstanding).
- Legal(a): a[1:0]==0 and PC_RESET ≤ a ≤ PC_LIMIT, unsigned 32-bit compare. Sequential candidate is `pc + 32'd4`, wrapping modulo 2^32.
- Priority, all states: `exc_req` > `eret_req` > state action.
- `exc_req`:
  - next_pc=HANDLER_PC, pc_en=1, flush=1.
  - Pending target discarded; state→RUN; exc_code←0.
- `eret_req`:
  - If Legal(epc): next_pc=epc, pc_en=1, flush=1, state→RUN.
  - Else: enter TRAP with bad_vaddr←epc.
- RUN, stall=1, br_valid=1: pc_en=0; capture br_target; state→PEND.
- RUN, stall=1, br_valid=0: pc_en=0; stay.
- RUN, stall=0: target = br_valid ? br_target : pc+4.
  - Legal: next_pc=target, pc_en=1.
  - Illegal: pc_en=0, enter TRAP, bad_vaddr←target.
- PEND:
  - br_valid ignored; pending target retained.
  - While stall=1: pc_en=0.
  - On stall=0: apply pending target with the same legality check as RUN, then state→RUN or TRAP.
- TRAP:
  - pc_en=0; exc_code=4; stall and br_valid ignored.
  - Exits only via exc_req; eret_req is also honoured.
- Branch delay slot: redirects never assert flush. Only exc_req and legal eret_req flush.
- When pc_en=0, next_pc = pc.

## Timing
- Reset (asynchronous): state=RUN, pending=0, exc_code=0, bad_vaddr=0.
- While reset is high: next_pc=PC_RESET, pc_en=0, flush=0.
- Redirect or exception request in cycle N: PC holds the new value after edge N+1. Zero added bubbles for an unstalled redirect.
- Pending redirect: applied in the first cycle with stall=0. PC updates at the following edge.
- exc_code/bad_vaddr become valid one edge after the illegal target is seen and hold until exc_req.
- exc_req in the same cycle as a fault: exc_req wins, and TRAP is not entered.
- Reset asserted mid-PEND or mid-TRAP: returns to RUN immediately; pending target lost.

## Structure
- Shared package `mips_defs`:
  - PC_RESET, PC_LIMIT, HANDLER_PC
  - ExcCode constants (EXC_ADEL=5'd4, EXC_NONE=5'd0)
  - state enum {RUN, PEND, TRAP}
- One sub-module `if_addr_chk`: combinational Legal(a) check. Instantiated once for the selected candidate.

## Test plan
- Reset then 4 idle cycles: pc_en=1 each cycle; next_pc 0x3004, 0x3008, 0x300c, 0x3010 as pc advances; exc_code=0.
- br_valid with br_target=0x3400 while stall=1 for 3 cycles, then stall=0: pc_en=0 for 3 cycles; next cycle next_pc=0x3400, pc_en=1, flush=0.
- pc=0x6ffc, no redirect: pc_en=0; after edge exc_code=4, bad_vaddr=0x7000; held until exc_req; then next_pc=0x4180, flush=1, exc_code→0.
- br_target=0x3402: TRAP with bad_vaddr=0x3402. eret_req with epc=0x2ffc: TRAP with bad_vaddr=0x2ffc.
- exc_req and eret_req (epc=0x3010) in the same cycle: next_pc=0x4180, flush=1.
- Reset pulse during PEND (pending 0x3400): outputs immediately next_pc=0x3000, pc_en=0; after release, sequential fetch resumes and 0x3400 is never issued.
